// File: rtl/shft_seq_32_pkg.sv
// Shared definitions for the bit-serial shift/rotate unit: function-select codes,
// sequencer states and the supported-op check.
package shft_seq_32_pkg;

   localparam logic [4:0] FS_SLL = 5'h0C;
   localparam logic [4:0] FS_SRL = 5'h0D;
   localparam logic [4:0] FS_SRA = 5'h0E;
   localparam logic [4:0] FS_ROL = 5'h10;
   localparam logic [4:0] FS_ROR = 5'h11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic fs_supported(input logic [4:0] fs);
      return (fs == FS_SLL) || (fs == FS_SRL) || (fs == FS_SRA) ||
             (fs == FS_ROL) || (fs == FS_ROR);
   endfunction

endpackage

// File: rtl/shft_seq_32_step.sv
// One-bit shift/rotate step: next working value and the bit that falls out.
// Unsupported ops pass the value through with a zero out-bit.
module shft_seq_32_step
   import shft_seq_32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [4:0]       op,
   output logic [WIDTH-1:0] nxt,
   output logic             out_bit
);

   always_comb begin
      nxt     = cur;
      out_bit = 1'b0;
      case (op)
         FS_SLL: begin
            nxt     = {cur[WIDTH-2:0], 1'b0};
            out_bit = cur[WIDTH-1];
         end
         FS_SRL: begin
            nxt     = {1'b0, cur[WIDTH-1:1]};
            out_bit = cur[0];
         end
         FS_SRA: begin
            nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
            out_bit = cur[0];
         end
         FS_ROL: begin
            nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
            out_bit = cur[WIDTH-1];
         end
         FS_ROR: begin
            nxt     = {cur[0], cur[WIDTH-1:1]};
            out_bit = cur[0];
         end
         default: begin
            nxt     = cur;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shft_seq_32.sv
// Multi-cycle shift/rotate sequencer: one bit position per clock with a
// start/busy/done handshake so the control unit can stall on it.
//
//   state | meaning
//   IDLE  | waiting for start; result and flags held
//   SHIFT | one step per clock, counter counts down to 1
//   DONE  | one-cycle done pulse; start here begins the next op immediately
module shft_seq_32
   import shft_seq_32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] T,
   input  logic [4:0]       FS,
   input  logic [CW-1:0]    shamnt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y_lo,
   output logic             C,
   output logic             N,
   output logic             Z,
   output logic             V
);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [4:0]       op;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] step_nxt;
   logic             step_bit;

   shft_seq_32_step #(.WIDTH(WIDTH)) u_step (
      .cur     (work),
      .op      (op),
      .nxt     (step_nxt),
      .out_bit (step_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         work  <= '0;
         op    <= '0;
         cnt   <= '0;
         C     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  work <= T;
                  op   <= FS;
                  cnt  <= shamnt;
                  C    <= 1'b0;
                  // nothing to shift: report the operand back after one cycle
                  if (shamnt == '0 || !fs_supported(FS)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            SHIFT: begin
               work <= step_nxt;
               C    <= step_bit;
               cnt  <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign Y_lo = work;
   assign N    = work[WIDTH-1];
   assign Z    = (work == '0);
   assign V    = 1'b0;

endmodule

// File: tb/tb_shft_seq_32.sv
// Bench for shft_seq_32: directed cases with literal expectations plus random
// ops, all checked every cycle against an arithmetic reference model.
module tb_shft_seq_32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] T = '0;
   logic [4:0]  FS = '0;
   logic [4:0]  shamnt = '0;
   logic        busy, done, C, N, Z, V;
   logic [31:0] Y_lo;

   int total = 0;
   int bad   = 0;

   shft_seq_32 #(.WIDTH(32), .CW(5)) dut (
      .clk(clk), .reset(reset), .start(start), .T(T), .FS(FS), .shamnt(shamnt),
      .busy(busy), .done(done), .Y_lo(Y_lo), .C(C), .N(N), .Z(Z), .V(V)
   );

   always #5 clk = ~clk;

   // whole-operation result from plain arithmetic: {C, Y}
   function automatic logic [32:0] ref_op(input logic [31:0] t, input logic [4:0] fs,
                                          input logic [4:0] s);
      logic [31:0] y;
      logic        c;
      int          n;
      n = int'(s);
      y = t;
      c = 1'b0;
      if (n != 0) begin
         case (fs)
            5'h0C: begin y = t << n; c = t[32-n]; end
            5'h0D: begin y = t >> n; c = t[n-1]; end
            5'h0E: begin y = 32'($signed(t) >>> n); c = t[n-1]; end
            5'h10: begin y = (t << n) | (t >> (32-n)); c = y[0]; end
            5'h11: begin y = (t >> n) | (t << (32-n)); c = y[31]; end
            default: ;
         endcase
      end
      return {c, y};
   endfunction

   function automatic int ref_lat(input logic [4:0] fs, input logic [4:0] s);
      if (s != 0 && (fs == 5'h0C || fs == 5'h0D || fs == 5'h0E ||
                     fs == 5'h10 || fs == 5'h11))
         return int'(s) + 1;
      return 1;
   endfunction

   // reference model: cycles remaining until done, and the result to expect
   logic        m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b1, m_c = 1'b0;
   logic [31:0] m_y = '0;
   int          m_left = 0;
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      logic [32:0] r;
      if (reset) begin
         m_busy = 0; m_done = 0; m_valid = 1; m_y = '0; m_c = 0; m_left = 0;
      end else if (!m_busy && start) begin
         r      = ref_op(T, FS, shamnt);
         m_y    = r[31:0];
         m_c    = r[32];
         m_left = ref_lat(FS, shamnt) - 1;
         m_busy = (m_left != 0);
         m_done = (m_left == 0);
         m_valid = m_done;
      end else if (m_busy) begin
         m_left = m_left - 1;
         m_busy = (m_left != 0);
         m_done = (m_left == 0);
         if (m_done) m_valid = 1;
      end else begin
         m_done = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("V", 32'(V), 32'd0);
         if (m_valid) begin
            chk("Y_lo", Y_lo, m_y);
            chk("C", 32'(C), 32'(m_c));
            chk("N", 32'(N), 32'(m_y[31]));
            chk("Z", 32'(Z), 32'(m_y == 0));
         end
      end
   end

   // present an op at the current negedge; returns at the negedge after acceptance
   task automatic issue_now(input logic [31:0] t, input logic [4:0] fs, input logic [4:0] s);
      T = t; FS = fs; shamnt = s; start = 1;
      @(negedge clk);
      start = 0;
      T = $urandom; FS = 5'($urandom); shamnt = 5'($urandom);
   endtask

   task automatic issue(input logic [31:0] t, input logic [4:0] fs, input logic [4:0] s);
      @(negedge clk);
      issue_now(t, fs, s);
   endtask

   // counts cycles from the accepting edge until done is seen
   task automatic wait_done(output int cyc, input bit poke);
      cyc = 1;
      while (!done && cyc < 40) begin
         if (poke && cyc == 2) begin
            T = $urandom; FS = 5'h0C; shamnt = 5'd0; start = 1;
         end
         @(negedge clk);
         start = 0;
         cyc++;
      end
      if (!done) begin
         bad++;
         total++;
         $display("FAIL wait_done timeout: got=no_done want=done");
      end
   endtask

   task automatic run(input string name, input logic [31:0] t, input logic [4:0] fs,
                      input logic [4:0] s, input int lat, input logic [31:0] y, input logic c);
      int cyc;
      issue(t, fs, s);
      wait_done(cyc, 0);
      chk({name, "_lat"}, 32'(cyc), 32'(lat));
      chk({name, "_y"}, Y_lo, y);
      chk({name, "_c"}, 32'(C), 32'(c));
   endtask

   initial begin
      int          cyc;
      logic [4:0]  fs_pick[6] = '{5'h0C, 5'h0D, 5'h0E, 5'h10, 5'h11, 5'h05};

      repeat (2) @(negedge clk);
      reset = 0;
      chk_en = 1;
      chk("rst_y", Y_lo, 32'h0);
      chk("rst_c", 32'(C), 32'd0);
      chk("rst_z", 32'(Z), 32'd1);
      chk("rst_n", 32'(N), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      run("sll1", 32'h8000_0001, 5'h0C, 5'd1, 2, 32'h0000_0002, 1'b1);
      chk("sll1_n", 32'(N), 32'd0);
      chk("sll1_z", 32'(Z), 32'd0);
      run("sra4", 32'h8000_00F0, 5'h0E, 5'd4, 5, 32'hF800_000F, 1'b0);
      chk("sra4_n", 32'(N), 32'd1);
      run("srl4", 32'h8000_00F0, 5'h0D, 5'd4, 5, 32'h0800_000F, 1'b0);
      run("ror31", 32'h0000_0001, 5'h11, 5'd31, 32, 32'h0000_0002, 1'b0);
      run("rol1", 32'h8000_0000, 5'h10, 5'd1, 2, 32'h0000_0001, 1'b1);
      run("sh0", 32'h1234_5678, 5'h0C, 5'd0, 1, 32'h1234_5678, 1'b0);
      run("badfs", 32'h1234_5678, 5'h05, 5'd7, 1, 32'h1234_5678, 1'b0);

      // start pulsed while busy must be ignored
      issue(32'hF000_0000, 5'h0D, 5'd8);
      wait_done(cyc, 1);
      chk("busy_ign_lat", 32'(cyc), 32'd9);
      chk("busy_ign_y", Y_lo, 32'h00F0_0000);

      // start held through done: second op accepted back-to-back
      @(negedge clk);
      T = 32'h1; FS = 5'h0C; shamnt = 5'd3; start = 1;
      @(negedge clk);
      T = 32'h10; FS = 5'h0D; shamnt = 5'd2;
      cyc = 0;
      while (!done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("b2b_first_y", Y_lo, 32'h8);
      @(negedge clk);
      start = 0;
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(cyc, 0);
      chk("b2b_second_y", Y_lo, 32'h4);

      // reset mid-shift aborts without a done pulse
      issue(32'hFFFF_FFFF, 5'h0D, 5'd16);
      repeat (6) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("abort_y", Y_lo, 32'h0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_z", 32'(Z), 32'd1);
      repeat (20) @(negedge clk);
      run("srl16", 32'h0001_0000, 5'h0D, 5'd16, 17, 32'h0000_0001, 1'b0);
      chk("srl16_z", 32'(Z), 32'd0);

      // random ops, checked by the per-cycle compare
      for (int i = 0; i < 60; i++) begin
         int          gap;
         logic [4:0]  s;
         logic [4:0]  fs;
         gap = $urandom_range(0, 3);
         fs  = fs_pick[$urandom_range(0, 5)];
         s   = 5'($urandom);
         if (gap == 0) issue_now($urandom, fs, s);
         else begin
            repeat (gap - 1) @(negedge clk);
            issue($urandom, fs, s);
         end
         wait_done(cyc, (s >= 5'd4) && ($urandom_range(0, 1) == 1));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
